// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 encodings, FSM state encoding and per-op signedness predicates.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f);
    return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
           (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f);
    return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: radix-2 shift/add for multiply,
// restoring shift/subtract for divide, both on unsigned magnitudes.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     dsr_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // Multiply keeps the carry so the shifted-in top bit is exact.
  assign sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, dsr_i} : '0);
  // Divide: partial remainder shifted left with the next dividend bit.
  assign trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, dsr_i};

  always_comb begin
    if (!is_div_i) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*WIDTH-2:WIDTH-1], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer with divide special cases
// resolved at start. States:
//   IDLE | waiting for start
//   PREP | magnitudes of signed operands, record signs
//   RUN  | WIDTH iterations of mdu_iter_step
//   FIX  | sign correction and half/quotient/remainder select
//   DONE | one-cycle done pulse
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 accept, sp_zero, sp_ovf, special;
  logic [WIDTH-1:0]     special_res, fix_res, mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0]   prod;
  logic                 neg_a_pre, neg_b_pre;

  assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign sp_zero = is_div(op) && (b == '0);
  assign sp_ovf  = is_div(op) && is_signed_a(op) && (a == MIN_NEG) && (b == ALL_ONES);
  assign special = sp_zero || sp_ovf;
  // op[1] distinguishes REM/REMU from DIV/DIVU.
  assign special_res = sp_zero ? (op[1] ? a : ALL_ONES) : (op[1] ? '0 : a);

  assign neg_a_pre = is_signed_a(op_q) && acc_q[WIDTH-1];
  assign neg_b_pre = is_signed_b(op_q) && dsr_q[WIDTH-1];
  assign mag_a     = neg_a_pre ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign mag_b     = neg_b_pre ? -dsr_q : dsr_q;

  assign prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    if (is_div(op_q)) fix_res = op_q[1] ? rem : quo;
    else              fix_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .dsr_i    (dsr_q),
    .acc_o    (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = special ? ST_DONE : ST_PREP;
        else        state_d = ST_IDLE;
      end
      ST_PREP: state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    if (accept) begin
      op_d    = op;
      acc_d   = {{WIDTH{1'b0}}, a};
      dsr_d   = b;
      cnt_d   = '0;
      neg_a_d = 1'b0;
      neg_b_d = 1'b0;
      if (special) result_d = special_res;
    end
    case (state_q)
      ST_PREP: begin
        neg_a_d = neg_a_pre;
        neg_b_d = neg_b_pre;
        acc_d   = {{WIDTH{1'b0}}, mag_a};
        dsr_d   = mag_b;
        cnt_d   = '0;
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      ST_FIX:  result_d = fix_res;
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_PREP, ST_RUN, ST_FIX: busy = 1'b1;
      ST_DONE:                 done = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed RV32M cases plus random operands
// against a plain-arithmetic reference model.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  result;

  mdu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    logic [2:0]   f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] last_res = '0;

  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int xi, yi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    xi = x;
    yi = y;
    case (f)
      OP_MUL:    begin p = 64'(ux * uy); return p[31:0];  end
      OP_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(xi / yi);
      end
      OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(xi % yi);
      end
      default:   return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    if (f[2] && (y == 0 || ((f == OP_DIV || f == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return W + 3;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: cycle %0d result %h, required no done", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res) begin
          n_fail++;
          $display("FAIL result op=%0d: got %h required %h", mon_e.f, result, mon_e.res);
        end
        n_checks++;
        if (cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL done_cycle op=%0d: got %0d required %0d", mon_e.f, cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the accepting edge follows.
  task automatic drive(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_res, output int n, output logic sp);
    exp_t e;
    int   lat;
    lat   = latency(f, x, y);
    sp    = (lat == 1);
    n     = cyc;
    e.res = exp_res;
    e.cyc = cyc + lat;
    e.f   = f;
    sb.push_back(e);
    last_res = exp_res;
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input int n, input logic sp, input int poke_k);
    int   k;
    logic exp_busy;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k = cyc - n;
      exp_busy = !sp && k >= 1 && k <= W + 2;
      check($sformatf("busy_k%0d", k), {31'b0, busy}, {31'b0, exp_busy});
      if (done) return;
      if (k == poke_k) begin
        start = 1'b1; op = OP_DIVU; a = 32'd99; b = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout: no done within 100 cycles, got none required one");
  endtask

  logic [2:0]   d_op [12] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                              OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM};
  logic [W-1:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [W-1:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [W-1:0] d_r  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  initial begin
    int           n;
    logic         sp;
    logic [2:0]   f;
    logic [W-1:0] x, y;
    int           sel;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First MUL also gets an ignored start poke at cycle 10; odd entries
    // leave two idle cycles so result hold is visible, even ones chain.
    for (int i = 0; i < 12; i++) begin
      drive(d_op[i], d_a[i], d_b[i], d_r[i], n, sp);
      wait_done(n, sp, (i == 0) ? 10 : -1);
      if (i % 2 == 1) begin
        repeat (2) @(negedge clk);
        check("idle_hold", result, last_res);
      end
    end

    // Reset in cycle 12 of a divide aborts it.
    drive(OP_DIV, 32'd1000, 32'd3, 32'd333, n, sp);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",   {31'b0, busy}, 32'd0);
    check("abort_done",   {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    drive(OP_MUL, 32'd3, 32'd4, 32'd12, n, sp);
    wait_done(n, sp, -1);

    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      else if (sel == 3) x = 32'($urandom_range(0, 300));
      drive(f, x, y, ref_model(f, x, y), n, sp);
      wait_done(n, sp, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
